// File: rtl/ctrl_decode_fsm_if.sv
// ctrl_decode_fsm_if
// Bundles the instruction-fetch handshake and the decoded control outputs
// that travel between the control FSM and the rest of the datapath.
//
// Signals:
//   instr        16  instruction word from instruction memory
//   instr_valid   1  instr holds the word at mem_addr this cycle
//   mem_addr     16  fetch address (always the current pc)
//   mem_rd        1  fetch request
//   reg_enable   16  one-hot register-bank write enable
//   rega_sel      4  A-port register select (Rdest)
//   regb_sel      4  B-port register select (Rsrc)
//   alu_opcode    8  ALU operation code
//   imm           8  immediate for the ALU B-input mux
//   imm_sel       1  ALU B-input takes imm instead of regb
//   flags_we      1  flag-register write strobe
//   illegal       1  sticky undefined-instruction indicator
//   halted        1  controller has executed the halt word
//
// Modports:
//   master  the control FSM (drives the decoded controls)
//   slave   memory / datapath side (drives instr and instr_valid)
interface ctrl_decode_fsm_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] reg_enable;
  logic [3:0]  rega_sel;
  logic [3:0]  regb_sel;
  logic [7:0]  alu_opcode;
  logic [7:0]  imm;
  logic        imm_sel;
  logic        flags_we;
  logic        illegal;
  logic        halted;

  modport master (
    input  instr, instr_valid,
    output mem_addr, mem_rd, reg_enable, rega_sel, regb_sel,
           alu_opcode, imm, imm_sel, flags_we, illegal, halted
  );

  modport slave (
    output instr, instr_valid,
    input  mem_addr, mem_rd, reg_enable, rega_sel, regb_sel,
           alu_opcode, imm, imm_sel, flags_we, illegal, halted
  );
endinterface

// File: rtl/ctrl_decode_fsm.sv
// ctrl_decode_fsm
// Multi-cycle fetch/decode/execute controller. Fetches one instruction
// word per pass, decodes it into register selects, ALU opcode and
// immediate controls, and strobes register and flag writes for exactly
// one EXECUTE cycle. The halt word parks the controller until reset.
//
// Parameters:
//   RESET_PC   pc value loaded on reset
//   HALT_WORD  instruction word that stops execution
//
// Ports:
//   clock  single clock, all state changes on the rising edge
//   reset  asynchronous active-high reset
//   bus    ctrl_decode_fsm_if.master (fetch handshake + decoded controls)
module ctrl_decode_fsm #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic               clock,
  input  logic               reset,
  ctrl_decode_fsm_if.master  bus
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] DECODE  = 2'd1;
  localparam logic [1:0] EXECUTE = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam logic [7:0] OP_NOP = 8'h17;

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        illegal_q;

  logic [7:0]  dec_opcode;
  logic [7:0]  dec_imm;
  logic        dec_imm_sel;
  logic        dec_write;
  logic        dec_flags;
  logic        dec_defined;
  logic        in_execute;

  // Instruction decode is purely a function of IR. Because IR resets to
  // 16'h0000 (a NOP with register fields of zero), the decoded outputs
  // automatically show the required idle values while reset is held.
  // Anything not listed falls through as an undefined NOP.
  always_comb begin
    dec_opcode  = OP_NOP;
    dec_imm     = 8'h00;
    dec_imm_sel = 1'b0;
    dec_write   = 1'b0;
    dec_flags   = 1'b0;
    dec_defined = 1'b0;
    case (ir[15:12])
      4'h0: begin
        dec_defined = 1'b1;
        case (ir[7:4])
          4'h5: begin dec_opcode = 8'h00; dec_write = 1'b1; dec_flags = 1'b1; end
          4'h6: begin dec_opcode = 8'h02; dec_write = 1'b1; dec_flags = 1'b1; end
          4'h9: begin dec_opcode = 8'h08; dec_write = 1'b1; dec_flags = 1'b1; end
          4'hB: begin dec_opcode = 8'h0A; dec_flags = 1'b1; end
          4'h1: begin dec_opcode = 8'h0D; dec_write = 1'b1; end
          4'h2: begin dec_opcode = 8'h0E; dec_write = 1'b1; end
          4'h3: begin dec_opcode = 8'h0F; dec_write = 1'b1; end
          4'h0: begin dec_opcode = OP_NOP; end
          default: dec_defined = 1'b0;
        endcase
      end
      4'h5, 4'h6, 4'h9, 4'hB: begin
        dec_defined = 1'b1;
        dec_imm     = ir[7:0];
        dec_imm_sel = 1'b1;
        dec_flags   = 1'b1;
        case (ir[15:12])
          4'h5:    begin dec_opcode = 8'h01; dec_write = 1'b1; end
          4'h6:    begin dec_opcode = 8'h03; dec_write = 1'b1; end
          4'h9:    begin dec_opcode = 8'h09; dec_write = 1'b1; end
          default: begin dec_opcode = 8'h0B; end
        endcase
      end
      4'h8: begin
        dec_defined = 1'b1;
        case (ir[7:4])
          4'h4: begin dec_opcode = 8'h11; dec_write = 1'b1; end
          4'h0: begin
            dec_opcode  = 8'h12;
            dec_write   = 1'b1;
            dec_imm     = {4'h0, ir[3:0]};
            dec_imm_sel = 1'b1;
          end
          4'h1: begin
            dec_opcode  = 8'h14;
            dec_write   = 1'b1;
            dec_imm     = {4'h0, ir[3:0]};
            dec_imm_sel = 1'b1;
          end
          default: dec_defined = 1'b0;
        endcase
      end
      default: dec_defined = 1'b0;
    endcase
  end

  // Controller state, program counter, instruction register and the
  // sticky illegal flag. The pc only moves at the end of EXECUTE, so a
  // halt word leaves it pointing at the halt word itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= (ir == HALT_WORD) ? HALT : EXECUTE;
        end
        EXECUTE: begin
          pc <= pc + 16'h0001;
          if (!dec_defined) begin
            illegal_q <= 1'b1;
          end
          state <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Write strobes are gated by the state decode rather than registered,
  // so an asynchronous reset mid-EXECUTE drops them immediately.
  assign in_execute     = (state == EXECUTE);
  assign bus.reg_enable = (in_execute && dec_write) ? (16'h0001 << ir[11:8]) : 16'h0000;
  assign bus.flags_we   = in_execute && dec_flags;

  assign bus.mem_addr   = pc;
  assign bus.mem_rd     = (state == FETCH);
  assign bus.rega_sel   = ir[11:8];
  assign bus.regb_sel   = ir[3:0];
  assign bus.alu_opcode = dec_opcode;
  assign bus.imm        = dec_imm;
  assign bus.imm_sel    = dec_imm_sel;
  assign bus.illegal    = illegal_q;
  assign bus.halted     = (state == HALT);

endmodule
